// File: rtl/spi_sd_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sd_master
//  Description : CPU-facing SPI mode-0 master for an SD card. Each write to
//                DATA runs one 8-bit MSB-first transfer. The spi_clk rate is
//                programmable and chip select is under software control.
//                A done flag is set when the byte completes and is cleared
//                by reading DATA.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sd_master #(
    parameter logic [7:0] DIV_RESET = 8'd24,
    parameter logic       CS_RESET  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       rwb,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       sd_cs,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [1:0] C_ADDR_DATA = 2'd0;
    localparam logic [1:0] C_ADDR_CTRL = 2'd1;
    localparam logic [1:0] C_ADDR_DIV  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] div_q;
    logic [7:0] div_act_q;      // divider in force for the current half-period
    logic [7:0] shreg_q;
    logic [7:0] rx_q;
    logic [2:0] bit_q;
    logic       busy_q;
    logic       done_q;
    logic       ovr_q;
    logic       wr_lvl_q;
    logic       rd_lvl_q;
    logic       sd_cs_q;
    logic       spi_clk_q;
    logic       spi_mosi_q;

    logic w_wr_lvl;
    logic w_rd_lvl;
    logic w_wr_stb;
    logic w_rd_stb;
    logic w_data_wr;
    logic w_ctrl_wr;
    logic w_div_wr;
    logic w_data_rd;

    // A bus access may last many clk cycles; only its first cycle commits.
    assign w_wr_lvl  = cs & ~rwb;
    assign w_rd_lvl  = cs & rwb;
    assign w_wr_stb  = w_wr_lvl & ~wr_lvl_q;
    assign w_rd_stb  = w_rd_lvl & ~rd_lvl_q;
    assign w_data_wr = w_wr_stb & (addr == C_ADDR_DATA);
    assign w_ctrl_wr = w_wr_stb & (addr == C_ADDR_CTRL);
    assign w_div_wr  = w_wr_stb & (addr == C_ADDR_DIV);
    assign w_data_rd = w_rd_stb & (addr == C_ADDR_DATA);

    assign sd_cs    = sd_cs_q;
    assign spi_clk  = spi_clk_q;
    assign spi_mosi = spi_mosi_q;

    // Register file, strobe edge detection and the transfer state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            div_q      <= DIV_RESET;
            div_act_q  <= DIV_RESET;
            shreg_q    <= 8'd0;
            rx_q       <= 8'hFF;
            bit_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            wr_lvl_q   <= 1'b0;
            rd_lvl_q   <= 1'b0;
            sd_cs_q    <= CS_RESET;
            spi_clk_q  <= 1'b0;
            spi_mosi_q <= 1'b1;
        end else begin
            wr_lvl_q <= w_wr_lvl;
            rd_lvl_q <= w_rd_lvl;

            if (w_ctrl_wr) begin
                sd_cs_q <= i_data[0];
                if (i_data[7]) begin
                    ovr_q <= 1'b0;
                end
            end

            if (w_div_wr) begin
                div_q <= i_data;
            end

            // Reading the byte clears done; a completion in the same cycle
            // is assigned later below and therefore wins.
            if (w_data_rd) begin
                done_q <= 1'b0;
            end

            if (w_data_wr && (state_q != ST_IDLE)) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_data_wr) begin
                        shreg_q    <= i_data;
                        spi_mosi_q <= i_data[7];
                        bit_q      <= 3'd0;
                        cnt_q      <= 8'd0;
                        div_act_q  <= div_q;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == div_act_q) begin
                        cnt_q     <= 8'd0;
                        div_act_q <= div_q;
                        spi_clk_q <= 1'b1;
                        shreg_q   <= {shreg_q[6:0], spi_miso};
                        state_q   <= ST_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == div_act_q) begin
                        cnt_q     <= 8'd0;
                        div_act_q <= div_q;
                        spi_clk_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            rx_q       <= shreg_q;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            spi_mosi_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            bit_q      <= bit_q + 3'd1;
                            spi_mosi_q <= shreg_q[7];
                            state_q    <= ST_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read mux: purely a function of the register index.
    always_comb begin
        o_data = 8'h00;
        case (addr)
            2'd0:    o_data = rx_q;
            2'd1:    o_data = {busy_q, done_q, ovr_q, 4'b0000, sd_cs_q};
            2'd2:    o_data = div_q;
            default: o_data = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_sd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_sd_master
//  Description : Self-checking bench for spi_sd_master. Expected bytes,
//                timings and status words come from a small model of the
//                register map and transfer rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_sd_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       rwb = 1'b1;
    logic [7:0] i_data = 8'd0;
    logic [7:0] o_data;
    logic       sd_cs;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso = 1'b1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic m_sdcs = 1'b1;
    logic m_ovr  = 1'b0;
    int   m_div  = 24;

    // Pin monitor state
    int         rises;
    int         cyc;
    int         rise_t[8];
    logic [7:0] cap;
    logic       prev_sclk;
    bit         mon_lb;
    logic [7:0] mon_mb;

    spi_sd_master #(.DIV_RESET(8'd24), .CS_RESET(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .addr     (addr),
        .rwb      (rwb),
        .i_data   (i_data),
        .o_data   (o_data),
        .sd_cs    (sd_cs),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat_word(input logic busy, input logic done);
        return {24'd0, busy, done, m_ovr, 4'b0000, m_sdcs};
    endfunction

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
        @(negedge clk);
        cs = 1'b0; rwb = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rwb = 1'b1; addr = a;
        #1 d = o_data;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Called once per falling clk edge: records spi_clk rises and the mosi
    // bit present at each, and drives miso (loopback or a chosen byte).
    task automatic mon();
        cyc++;
        if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
            if (rises < 8) rise_t[rises] = cyc;
            cap = {cap[6:0], spi_mosi};
            rises++;
        end
        prev_sclk = spi_clk;
        if (mon_lb) spi_miso = spi_mosi;
        else if (rises < 8) spi_miso = mon_mb[3'(7 - rises)];
        else spi_miso = 1'b1;
    endtask

    task automatic mon_start(input bit lb, input logic [7:0] mb);
        rises = 0; cyc = 0; cap = 8'd0; prev_sclk = spi_clk;
        mon_lb = lb; mon_mb = mb;
        spi_miso = lb ? 1'b1 : mb[7];
    endtask

    // One complete transfer: DATA write held for 'hold' cycles, optional
    // second DATA write while busy, then busy is polled through STAT.
    task automatic do_xfer(input string tag, input logic [7:0] tx, input int hold,
                           input bit lb, input logic [7:0] mb, input bit inject);
        int         busy_cnt;
        bit         timeout;
        logic [7:0] rd;
        logic [7:0] exp_rx;
        mon_start(lb, mb);
        busy_cnt = 0;
        @(negedge clk);
        cs = 1'b1; rwb = 1'b0; addr = 2'd0; i_data = tx;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); mon(); busy_cnt++;
        end
        if (inject) begin
            cs = 1'b0;
            @(negedge clk); mon(); busy_cnt++;
            cs = 1'b1; i_data = 8'h12;
            @(negedge clk); mon(); busy_cnt++;
            m_ovr = 1'b1;
        end
        cs = 1'b1; rwb = 1'b1; addr = 2'd1;
        timeout = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk); mon();
            if (o_data[7]) busy_cnt++;
            else begin timeout = 1'b0; break; end
        end
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); mon();
        end
        exp_rx = lb ? tx : mb;
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(16 * (m_div + 1)));
        check({tag, "_pulses"},   32'(rises), 32'd8);
        check({tag, "_mosi"},     {24'd0, cap}, {24'd0, tx});
        check({tag, "_period"},   32'(rise_t[1] - rise_t[0]), 32'(2 * (m_div + 1)));
        check({tag, "_first"},    32'(rise_t[0]), 32'(m_div + 2));
        check({tag, "_mosi_idle"}, {31'd0, spi_mosi}, 32'd1);
        check({tag, "_stat_done"}, {24'd0, o_data}, stat_word(1'b0, 1'b1));
        cs = 1'b0;
        bus_rd(2'd0, rd);
        check({tag, "_rx"}, {24'd0, rd}, {24'd0, exp_rx});
        bus_rd(2'd1, rd);
        check({tag, "_stat_clr"}, {24'd0, rd}, stat_word(1'b0, 1'b0));
    endtask

    task automatic set_div(input int d);
        logic [7:0] rd;
        bus_wr(2'd2, 8'(d));
        m_div = d;
        bus_rd(2'd2, rd);
        check("div_rb", {24'd0, rd}, 32'(d));
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] tx;
        logic [7:0] mb;
        bit         lb;
        bit         cbit;
        bit         timeout;

        // 1: reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_sclk",  {31'd0, spi_clk}, 32'd0);
        check("rst_mosi",  {31'd0, spi_mosi}, 32'd1);
        check("rst_sdcs",  {31'd0, sd_cs}, 32'd1);
        bus_rd(2'd1, rd); check("rst_stat", {24'd0, rd}, 32'h01);
        bus_rd(2'd2, rd); check("rst_div",  {24'd0, rd}, 32'd24);
        bus_rd(2'd0, rd); check("rst_data", {24'd0, rd}, 32'hFF);

        // 2: loopback A5 at DIV=1 with chip select asserted
        bus_wr(2'd1, 8'h00); m_sdcs = 1'b0;
        check("cs_pin", {31'd0, sd_cs}, 32'd0);
        set_div(1);
        do_xfer("t2", 8'hA5, 1, 1'b1, 8'h00, 1'b0);

        // 3: a DATA write held for 10 cycles starts exactly one transfer
        do_xfer("t3", 8'h3C, 10, 1'b1, 8'h00, 1'b0);

        // 4: DATA write while busy is ignored and flags overrun
        do_xfer("t4", 8'hA7, 1, 1'b1, 8'h00, 1'b1);
        bus_wr(2'd1, 8'h80); m_ovr = 1'b0; m_sdcs = 1'b0;
        bus_rd(2'd1, rd); check("ovr_clr", {24'd0, rd}, stat_word(1'b0, 1'b0));

        // 5: miso held low, fastest rate
        set_div(0);
        do_xfer("t5", 8'hFF, 1, 1'b0, 8'h00, 1'b0);

        // Completion and DATA read strobe in the same cycle: done stays set
        spi_miso = 1'b0;
        bus_wr(2'd0, 8'h5A);
        repeat (15) @(negedge clk);
        cs = 1'b1; rwb = 1'b1; addr = 2'd0;
        @(negedge clk);
        addr = 2'd1;
        #1 check("race_stat", {24'd0, o_data}, stat_word(1'b0, 1'b1));
        cs = 1'b0;
        bus_rd(2'd0, rd); check("race_rx", {24'd0, rd}, 32'h00);
        bus_rd(2'd1, rd); check("race_clr", {24'd0, rd}, stat_word(1'b0, 1'b0));

        // Randomised transfers: random rate, chip select, data and miso source
        for (int k = 0; k < 5; k++) begin
            cbit = 1'($urandom_range(1, 0));
            bus_wr(2'd1, {7'd0, cbit}); m_sdcs = cbit;
            set_div(int'($urandom_range(3, 0)));
            tx = 8'($urandom);
            mb = 8'($urandom);
            lb = 1'($urandom_range(1, 0));
            do_xfer("rnd", tx, 1, lb, mb, 1'b0);
        end

        // Slowest divider: 256-cycle half-period
        set_div(255);
        do_xfer("div255", 8'($urandom), 1, 1'b0, 8'($urandom), 1'b0);

        // 6: reset during bit 3 aborts the transfer
        set_div(1);
        mon_start(1'b1, 8'h00);
        bus_wr(2'd0, 8'hC3);
        timeout = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); mon();
            if (rises == 4) begin timeout = 1'b0; break; end
        end
        check("t6_reach_bit3", 32'(timeout), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_sclk", {31'd0, spi_clk}, 32'd0);
        check("t6_mosi", {31'd0, spi_mosi}, 32'd1);
        check("t6_sdcs", {31'd0, sd_cs}, 32'd1);
        rst_n = 1'b1;
        m_sdcs = 1'b1; m_ovr = 1'b0; m_div = 24;
        bus_rd(2'd1, rd); check("t6_stat", {24'd0, rd}, 32'h01);
        bus_rd(2'd2, rd); check("t6_div",  {24'd0, rd}, 32'd24);
        bus_rd(2'd0, rd); check("t6_data", {24'd0, rd}, 32'hFF);
        do_xfer("t6_after", 8'h6E, 1, 1'b0, 8'h9D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
